// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers N_SCORES exp() scores and emits e_i/sum(e) in UQ0.8 via a bit-serial divider.
// Optional macro SOFTMAX_ROUND_EN selects round-half-up division instead of truncation.
//
// state | meaning
// FILL  | accepting scores, accumulating the sum
// DIV   | 9-cycle restoring division for weight idx
// OUT   | weight idx presented, waiting for m_ready
module softmax_norm #(
  parameter int N_SCORES = 4,
  parameter int IN_W     = 9,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last
);

  localparam int SUM_W = IN_W + $clog2(N_SCORES);
  localparam int IDX_W = $clog2(N_SCORES);
  localparam int Q_W   = OUT_W + 1;
  localparam int REM_W = SUM_W + Q_W;
  localparam int CNT_W = $clog2(Q_W);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(Q_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCORES - 1);
  localparam logic [Q_W-1:0]   Q_MAX    = Q_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {
    FILL,
    DIV,
    OUT
  } state_t;

  state_t state, state_next;

  logic [IN_W-1:0]  score_buf [N_SCORES];
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] bit_cnt;
  logic [REM_W-1:0] rem;
  logic [OUT_W-1:0] q;

  logic [REM_W-1:0] round_term;
  logic [REM_W-1:0] dividend;
  logic [REM_W-1:0] rem_cur;
  logic [REM_W-1:0] div_term;
  logic [REM_W-1:0] rem_next;
  logic             take;
  logic [Q_W-1:0]   q_next;
  logic [OUT_W-1:0] weight;

`ifdef SOFTMAX_ROUND_EN
  assign round_term = REM_W'(sum >> 1);
`else
  assign round_term = '0;
`endif

  // The first DIV cycle takes the dividend directly, so sum is already final when it is used.
  always_comb begin
    dividend = REM_W'({score_buf[idx], {OUT_W{1'b0}}}) + round_term;
    rem_cur  = (bit_cnt == CNT_LOAD) ? dividend : rem;
    div_term = REM_W'(sum) << bit_cnt;
    take     = (rem_cur >= div_term);
    rem_next = take ? (rem_cur - div_term) : rem_cur;
    q_next   = {q, take};
    if (sum == '0) begin
      weight = '0;
    end else if (q_next > Q_MAX) begin
      weight = '1;
    end else begin
      weight = q_next[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && idx == LAST_IDX) begin
          state_next = DIV;
        end
      end
      DIV: begin
        if (bit_cnt == '0) begin
          state_next = OUT;
        end
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_next = m_last ? FILL : DIV;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SCORES; i++) begin
        score_buf[i] <= '0;
      end
      sum     <= '0;
      idx     <= '0;
      bit_cnt <= CNT_LOAD;
      rem     <= '0;
      q       <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (s_valid) begin
            score_buf[idx] <= s_data;
            sum            <= sum + SUM_W'(s_data);
            idx            <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            bit_cnt        <= CNT_LOAD;
          end
        end
        DIV: begin
          rem     <= rem_next;
          q       <= q_next[OUT_W-1:0];
          bit_cnt <= bit_cnt - CNT_W'(1);
          if (bit_cnt == '0) begin
            m_data <= weight;
            m_last <= (idx == LAST_IDX);
          end
        end
        OUT: begin
          if (m_ready) begin
            bit_cnt <= CNT_LOAD;
            if (m_last) begin
              sum <= '0;
              idx <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// Bench for softmax_norm: random groups checked against an arithmetic model, plus literal group results,
// backpressure hold and reset-in-DIV scenarios.
module tb_softmax_norm;

  localparam int N = 4;

`ifdef SOFTMAX_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [8:0] s_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ref_cyc = 0;
  logic rand_rdy = 1'b0;
  logic prev_v = 1'b0;

  typedef struct {
    logic [7:0] w;
    logic       last;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] got[$];

  softmax_norm dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Weight from the definition: e*256/sum (optionally +sum/2), saturate at 255, zero sum gives 0.
  function automatic int model_w(input int e, input int sum);
    int q;
    if (sum == 0) return 0;
    q = (e * 256 + ROUND * (sum / 2)) / sum;
    return (q > 255) ? 255 : q;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (m_valid) begin
        if (!prev_v) check("latency", cyc - ref_cyc, 9);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: m_data=%0d with nothing expected", m_data);
        end else begin
          check("m_data", m_data, expq[0].w);
          check("m_last", m_last, expq[0].last);
          check("s_ready_busy", s_ready, 0);
          if (m_ready) begin
            got.push_back(m_data);
            void'(expq.pop_front());
            ref_cyc = cyc + 1;
          end
        end
      end
      prev_v = m_valid;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_score(input int v, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 9'(v);
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL timeout_s_ready: waited %0d cycles, required < 3000", n);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 9'($urandom_range(0, 511));
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d, input int max_gap);
    int sc[4];
    int sum;
    exp_t e;
    sc = '{a, b, c, d};
    sum = a + b + c + d;
    for (int i = 0; i < N; i++) send_score(sc[i], $urandom_range(0, max_gap));
    ref_cyc = cyc;
    for (int i = 0; i < N; i++) begin
      e.w    = 8'(model_w(sc[i], sum));
      e.last = (i == N - 1);
      expq.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_drain: %0d weights outstanding, required 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic directed(input string name, input int a, input int b, input int c, input int d,
                          input int w0, input int w1, input int w2, input int w3);
    int w[4];
    w = '{w0, w1, w2, w3};
    got.delete();
    send_group(a, b, c, d, 0);
    wait_drain();
    check({name, "_count"}, got.size(), 4);
    for (int i = 0; i < N && i < got.size(); i++) check(name, got[i], w[i]);
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_valid && n < 200);
    if (!m_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout_m_valid: m_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    logic [7:0] d0;
    logic       l0;
    int         sc[4];

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);

    check("model_pin_trunc_round", model_w(3, 10), ROUND ? 77 : 76);
    check("model_pin_sat", model_w(64, 64), 255);

    @(posedge clk);
    #1;
    m_ready = 1'b1;
    directed("equal", 64, 64, 64, 64, 64, 64, 64, 64);
    directed("saturate", 64, 0, 0, 0, 255, 0, 0, 0);
    directed("sum250", 100, 50, 50, 50, 102, 51, 51, 51);
    if (ROUND != 0) directed("round", 3, 3, 3, 1, 77, 77, 77, 26);
    else            directed("trunc", 3, 3, 3, 1, 76, 76, 76, 25);
    directed("zero_sum", 0, 0, 0, 0, 0, 0, 0, 0);

    // Backpressure: release weight 1, then hold weight 2 for 20 cycles.
    m_ready = 1'b0;
    got.delete();
    send_group(64, 64, 64, 64, 0);
    wait_mvalid();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    wait_mvalid();
    d0 = m_data;
    l0 = m_last;
    repeat (20) begin
      @(negedge clk);
      check("hold_m_data", m_data, d0);
      check("hold_m_last", m_last, l0);
      check("hold_m_valid", m_valid, 1);
      check("hold_s_ready", s_ready, 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drain();
    check("bp_count", got.size(), 4);

    // Reset while dividing discards the group.
    send_group(100, 50, 50, 50, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    expq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_div_m_valid", m_valid, 0);
    check("rst_div_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    directed("after_reset", 64, 64, 64, 64, 64, 64, 64, 64);

    rand_rdy = 1'b1;
    for (int g = 0; g < 30; g++) begin
      for (int i = 0; i < N; i++) begin
        sc[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 511));
      end
      send_group(sc[0], sc[1], sc[2], sc[3], 2);
    end
    wait_drain();
    rand_rdy = 1'b0;

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
Downstream stage of the attention MAC/exp engine. It takes N_SCORES unnormalised exp() scores (UQ3.6, 9-bit) over a valid/ready handshake and buffers them while accumulating their sum. It then emits N_SCORES attention weights, each w_i = e_i / sum(e) in UQ0.8, over a second valid/ready handshake. The division is a bit-serial restoring divider, one quotient bit per cycle, so the block stays small enough for the TinyTapeout area budget.

Parameters:
- N_SCORES, 4, scores per softmax group; must be ≥2.
- IN_W, 9, input score width (UQ3.6).
- OUT_W, 8, output weight width (UQ0.8).
- SUM_W, IN_W+$clog2(N_SCORES) (11 by default), accumulator width; derived, never overridden.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset; synchronous, active-low.
- s_valid, in, 1, input score valid.
- s_ready, out, 1, block can accept a score.
- s_data, in, IN_W, score e_i, UQ3.6, unsigned.
- m_valid, out, 1, output weight valid.
- m_ready, in, 1, consumer accepts the weight.
- m_data, out, OUT_W, weight w_i, UQ0.8.
- m_last, out, 1, high with the final weight of a group.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=FILL; index, sum and buffer cleared.
  - s_ready=1, m_valid=0, m_data=0, m_last=0.
  - Reset mid-group discards all partial data, including a pending output.
- FILL state:
  - s_ready=1.
  - Each edge with s_valid&s_ready: buf[idx]<=s_data, sum<=sum+s_data, idx++.
  - The edge accepting score N_SCORES-1 moves to DIV with idx=0.
- DIV state:
  - s_ready=0.
  - Computes q = floor(buf[idx]*256 / sum) using a restoring divider with dividend {buf[idx],8'b0} and divisor sum.
  - Takes exactly 9 cycles, MSB first, producing a 9-bit q.
  - On the 9th edge: m_data <= (q>255) ? 255 : q[7:0], m_valid<=1, m_last<=(idx==N_SCORES-1), state=OUT.
- Zero-sum rule: if sum==0, the divider is skipped; m_data=0 and the block still takes the same 9 cycles, so latency is constant.
- OUT state:
  - m_valid=1. m_data and m_last stay stable until m_valid&m_ready.
  - On the handshake edge, m_valid<=0.
  - If the weight was not the last: idx++ and return to DIV.
  - If it was the last: sum<=0, idx<=0, state=FILL, with s_ready=1 from the next cycle.
- Timing:
  - Latency from the last input accept to the first m_valid is 9 cycles.
  - Each subsequent weight appears 9 cycles after the previous handshake.
  - Minimum group period is N_SCORES + N_SCORES*10 cycles.
- Backpressure: m_ready may be held low indefinitely; there is no loss or corruption.
- Input side:
  - s_valid while s_ready=0 is ignored; the producer holds its data per the handshake rules.
  - s_ready is registered-state-based only, with no combinational path from m_ready.
- Overflow: SUM_W guarantees no accumulator overflow (4*511=2044 < 2048).
- Saturation: q=256 occurs only when e_i==sum (all other scores 0) and saturates to 255.

Optional Feature:
- Macro: SOFTMAX_ROUND_EN.
- Defined: dividend becomes {buf[idx],8'b0} + (sum>>1), so q = round-half-up(e_i*256/sum). Saturation to 255 and the zero-sum rule are unchanged, as is the 9-cycle latency.
- Undefined: truncating division as above.

Test Plan:
- Scores 64,64,64,64 with m_ready=1 → weights 64,64,64,64; m_last only on the 4th; first m_valid 9 cycles after the 4th accept.
- Scores 64,0,0,0 → 255,0,0,0 (saturation).
- Scores 100,50,50,50 (sum 250) → 102,51,51,51 in both builds.
- Scores 3,3,3,1 (sum 10):
  - Truncating build → 76,76,76,25.
  - SOFTMAX_ROUND_EN build → 77,77,77,26.
- Scores 0,0,0,0 → 0,0,0,0 with normal timing.
- Backpressure and reset:
  - Hold m_ready=0 for 20 cycles during weight 2 → m_data/m_last stable, s_ready=0 throughout.
  - Assert rst_n=0 during DIV → next cycle m_valid=0, s_ready=1.
  - A fresh group 64×4 then yields 64×4.
